vertical_controller: RTL and testbench

Generates frame-level VGA timing for the 640x480@60 display path: the active-low VSYNC pulse, the V_Frame_ON display-window qualifier, and the 7-bit row address into the 128x96 pixel memory. It sits directly upstream of horizontal_controller. That block runs its line sequence only while V_Frame_ON=1 and is held at line start otherwise. Both blocks share the 50 MHz pixel-domain clock, with 1600 clocks per line.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/line_tick_gen.sv | 43 ++++
 rtl/vertical_controller.sv | 137 +++++++++++++
 tb/tb_vertical_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the 640x480@60 display path (50 MHz clock).
// Holds the vertical state encodings, the horizontal segment lengths that
// define one line, the default vertical line counts and the pixel-memory
// geometry. LINE_CYCLES is derived here from the horizontal segments, so the
// horizontal and vertical controllers cannot disagree on the line length.
package vga_timing_pkg;

  // Vertical frame phases
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    BP   = 2'd1,
    DISP = 2'd2,
    FP   = 2'd3
  } vstate_t;

  // Horizontal segments in 50 MHz clocks (twice the 25 MHz pixel timing)
  localparam int H_B_CYCLES = 192;  // sync pulse
  localparam int H_C_CYCLES = 96;   // back porch
  localparam int H_D_CYCLES = 1280; // visible
  localparam int H_E_CYCLES = 32;   // front porch

  localparam int LINE_CYCLES = H_B_CYCLES + H_C_CYCLES + H_D_CYCLES + H_E_CYCLES;

  // Default vertical line counts
  localparam int SYNC_LINES    = 2;
  localparam int BP_LINES      = 33;
  localparam int DISP_LINES    = 480;
  localparam int FP_LINES      = 10;
  localparam int LINES_PER_ROW = 5;

  // Pixel memory geometry
  localparam int ROW_COUNT = 96;
  localparam int COL_COUNT = 128;

  // Last value of a 9-bit line-within-state counter for a phase of n lines
  function automatic logic [8:0] last_line(input int n);
    return 9'(n - 1);
  endfunction

endpackage

// File: rtl/line_tick_gen.sv
// Free-running line counter.
// Counts 0..LINE_CYCLES-1 and wraps; line_tick is high for the single cycle
// in which the counter holds its last value, i.e. the last clock of a line.
// Ports:
//   clk       in  clock
//   reset     in  asynchronous active-high reset (counter returns to 0)
//   line_tick out one-cycle pulse on the last clock of every line
module line_tick_gen #(
  parameter int LINE_CYCLES = 1600,
  parameter int CNT_W       = 11
) (
  input  logic clk,
  input  logic reset,
  output logic line_tick
);

  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_CYCLES - 1);

  logic [CNT_W-1:0] line_cnt_r;
  logic [CNT_W-1:0] line_cnt_next_s;

  // Next count: wrap on the last value of the line
  always_comb begin
    line_cnt_next_s = line_cnt_r;
    if (line_cnt_r == LINE_LAST) begin
      line_cnt_next_s = {CNT_W{1'b0}};
    end else begin
      line_cnt_next_s = line_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Line counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt_r <= {CNT_W{1'b0}};
    end else begin
      line_cnt_r <= line_cnt_next_s;
    end
  end

  assign line_tick = (line_cnt_r == LINE_LAST);

endmodule

// File: rtl/vertical_controller.sv
// Vertical VGA timing generator.
// Sequences SYNC -> BP -> DISP -> FP once per frame, one line being
// LINE_CYCLES clocks. Outputs are registered from the next-state value so they
// change in the same cycle as the state register and never glitch.
// Ports:
//   clk        in  50 MHz clock
//   reset      in  asynchronous active-high reset
//   VSYNC      out vertical sync, active low (low during SYNC)
//   V_Frame_ON out high during DISP; enables the horizontal controller
//   addr       out pixel-memory row 0..95, valid while V_Frame_ON=1, else 0
module vertical_controller #(
  parameter int LINE_CYCLES   = vga_timing_pkg::LINE_CYCLES,
  parameter int SYNC_LINES    = vga_timing_pkg::SYNC_LINES,
  parameter int BP_LINES      = vga_timing_pkg::BP_LINES,
  parameter int DISP_LINES    = vga_timing_pkg::DISP_LINES,
  parameter int FP_LINES      = vga_timing_pkg::FP_LINES,
  parameter int LINES_PER_ROW = vga_timing_pkg::LINES_PER_ROW
) (
  input  logic       clk,
  input  logic       reset,
  output logic       VSYNC,
  output logic       V_Frame_ON,
  output logic [6:0] addr
);

  import vga_timing_pkg::*;

  localparam logic [8:0] SYNC_LAST = last_line(SYNC_LINES);
  localparam logic [8:0] BP_LAST   = last_line(BP_LINES);
  localparam logic [8:0] DISP_LAST = last_line(DISP_LINES);
  localparam logic [8:0] FP_LAST   = last_line(FP_LINES);
  localparam logic [2:0] ROW_LAST  = 3'(LINES_PER_ROW - 1);

  vstate_t    state_r;
  vstate_t    next_state_s;
  logic [8:0] state_line_cnt_r;
  logic [8:0] state_line_cnt_next_s;
  logic [2:0] row_line_cnt_r;
  logic [2:0] row_line_cnt_next_s;
  logic [6:0] addr_r;
  logic [6:0] addr_next_s;
  logic       vsync_r;
  logic       frame_on_r;
  logic       line_tick_s;
  logic       in_disp_s;

  line_tick_gen #(
    .LINE_CYCLES (LINE_CYCLES),
    .CNT_W       (11)
  ) u_line_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .line_tick (line_tick_s)
  );

  // Next-state decode: each phase ends on the tick of its last line
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SYNC: begin
        if (line_tick_s && (state_line_cnt_r == SYNC_LAST)) next_state_s = BP;
        else next_state_s = SYNC;
      end
      BP: begin
        if (line_tick_s && (state_line_cnt_r == BP_LAST)) next_state_s = DISP;
        else next_state_s = BP;
      end
      DISP: begin
        if (line_tick_s && (state_line_cnt_r == DISP_LAST)) next_state_s = FP;
        else next_state_s = DISP;
      end
      FP: begin
        if (line_tick_s && (state_line_cnt_r == FP_LAST)) next_state_s = SYNC;
        else next_state_s = FP;
      end
      default: next_state_s = SYNC;
    endcase
  end

  // Staying in DISP across this edge: the only time row/addr may advance
  assign in_disp_s = (state_r == DISP) && (next_state_s == DISP);

  // Counter and address update; a state change clears before any increment
  always_comb begin
    state_line_cnt_next_s = state_line_cnt_r;
    row_line_cnt_next_s   = row_line_cnt_r;
    addr_next_s           = addr_r;

    if (next_state_s != state_r) begin
      state_line_cnt_next_s = 9'd0;
    end else if (line_tick_s) begin
      state_line_cnt_next_s = state_line_cnt_r + 9'd1;
    end else begin
      state_line_cnt_next_s = state_line_cnt_r;
    end

    // Entering or leaving DISP zeroes row and addr; the last DISP tick
    // therefore yields 0 instead of ROW_COUNT.
    if (!in_disp_s) begin
      row_line_cnt_next_s = 3'd0;
      addr_next_s         = 7'd0;
    end else if (line_tick_s && (row_line_cnt_r == ROW_LAST)) begin
      row_line_cnt_next_s = 3'd0;
      addr_next_s         = addr_r + 7'd1;
    end else if (line_tick_s) begin
      row_line_cnt_next_s = row_line_cnt_r + 3'd1;
      addr_next_s         = addr_r;
    end else begin
      row_line_cnt_next_s = row_line_cnt_r;
      addr_next_s         = addr_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= SYNC;
      state_line_cnt_r <= 9'd0;
      row_line_cnt_r   <= 3'd0;
      addr_r           <= 7'd0;
      vsync_r          <= 1'b0;
      frame_on_r       <= 1'b0;
    end else begin
      state_r          <= next_state_s;
      state_line_cnt_r <= state_line_cnt_next_s;
      row_line_cnt_r   <= row_line_cnt_next_s;
      addr_r           <= addr_next_s;
      vsync_r          <= (next_state_s != SYNC);
      frame_on_r       <= (next_state_s == DISP);
    end
  end

  assign VSYNC      = vsync_r;
  assign V_Frame_ON = frame_on_r;
  assign addr       = addr_r;

endmodule

// File: tb/tb_vertical_controller.sv
// Directed test of vertical_controller. Three instances share clock and reset:
//   d0: default 640x480 timing (frame 840000 clocks, only the first 64k run)
//   d1: LINE_CYCLES=16, 1/1/10/1 lines, 5 lines/row (frame 208 clocks)
//   d2: LINE_CYCLES=4, 2/33/480/10 lines, 5 lines/row (frame 2100 clocks,
//       full 96-row address range)
// Cycle n = value seen after n rising edges since reset release, sampled on
// the falling edge.
module tb_vertical_controller;

  logic       clk;
  logic       reset;
  logic [2:0] vs_s;
  logic [2:0] fo_s;
  logic [6:0] ad0_s, ad1_s, ad2_s;
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         max_ad [3];

  typedef struct {
    int         cyc;
    int         dut;
    logic       vs;
    logic       fo;
    logic [6:0] ad;
  } vec_t;

  vec_t vecs[$];

  vertical_controller u_d0 (
    .clk(clk), .reset(reset), .VSYNC(vs_s[0]), .V_Frame_ON(fo_s[0]), .addr(ad0_s)
  );

  vertical_controller #(
    .LINE_CYCLES(16), .SYNC_LINES(1), .BP_LINES(1), .DISP_LINES(10),
    .FP_LINES(1), .LINES_PER_ROW(5)
  ) u_d1 (
    .clk(clk), .reset(reset), .VSYNC(vs_s[1]), .V_Frame_ON(fo_s[1]), .addr(ad1_s)
  );

  vertical_controller #(
    .LINE_CYCLES(4), .SYNC_LINES(2), .BP_LINES(33), .DISP_LINES(480),
    .FP_LINES(10), .LINES_PER_ROW(5)
  ) u_d2 (
    .clk(clk), .reset(reset), .VSYNC(vs_s[2]), .V_Frame_ON(fo_s[2]), .addr(ad2_s)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Cycle counter, zero while reset is held
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Track the highest address each instance ever shows
  always @(negedge clk) begin
    if (!reset) begin
      if (int'(ad0_s) > max_ad[0]) max_ad[0] <= int'(ad0_s);
      if (int'(ad1_s) > max_ad[1]) max_ad[1] <= int'(ad1_s);
      if (int'(ad2_s) > max_ad[2]) max_ad[2] <= int'(ad2_s);
    end
  end

  function automatic void add(input int c, input int d, input logic v,
                              input logic f, input logic [6:0] a);
    vec_t e;
    e.cyc = c; e.dut = d; e.vs = v; e.fo = f; e.ad = a;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input int d, input logic evs,
                       input logic efo, input logic [6:0] ead);
    logic       gvs, gfo;
    logic [6:0] gad;
    gvs = vs_s[d];
    gfo = fo_s[d];
    case (d)
      0:       gad = ad0_s;
      1:       gad = ad1_s;
      default: gad = ad2_s;
    endcase
    n_checks++;
    if (gvs !== evs || gfo !== efo || gad !== ead) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got VSYNC=%b V_Frame_ON=%b addr=%0d, expected VSYNC=%b V_Frame_ON=%b addr=%0d",
               name, d, cyc, gvs, gfo, gad, evs, efo, ead);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      while (cyc < vecs[i].cyc) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].vs, vecs[i].fo, vecs[i].ad);
    end
  endtask

  initial begin
    int n_first;
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 3; k++) max_ad[k] = 0;

    // Free-run vectors from the first reset release (sorted by cycle)
    add(0, 0, 1'b0, 1'b0, 7'd0);
    add(0, 1, 1'b0, 1'b0, 7'd0);
    add(0, 2, 1'b0, 1'b0, 7'd0);
    add(7, 2, 1'b0, 1'b0, 7'd0);
    add(8, 2, 1'b1, 1'b0, 7'd0);
    add(15, 1, 1'b0, 1'b0, 7'd0);
    add(16, 1, 1'b1, 1'b0, 7'd0);
    add(31, 1, 1'b1, 1'b0, 7'd0);
    add(32, 1, 1'b1, 1'b1, 7'd0);
    add(111, 1, 1'b1, 1'b1, 7'd0);
    add(112, 1, 1'b1, 1'b1, 7'd1);
    add(139, 2, 1'b1, 1'b0, 7'd0);
    add(140, 2, 1'b1, 1'b1, 7'd0);
    add(159, 2, 1'b1, 1'b1, 7'd0);
    add(160, 2, 1'b1, 1'b1, 7'd1);
    add(191, 1, 1'b1, 1'b1, 7'd1);
    add(192, 1, 1'b1, 1'b0, 7'd0);
    add(207, 1, 1'b1, 1'b0, 7'd0);
    add(208, 1, 1'b0, 1'b0, 7'd0);
    add(240, 1, 1'b1, 1'b1, 7'd0);
    add(1000, 2, 1'b1, 1'b1, 7'd43);
    add(2040, 2, 1'b1, 1'b1, 7'd95);
    add(2059, 2, 1'b1, 1'b1, 7'd95);
    add(2060, 2, 1'b1, 1'b0, 7'd0);
    add(2099, 2, 1'b1, 1'b0, 7'd0);
    add(2100, 2, 1'b0, 1'b0, 7'd0);
    add(2240, 2, 1'b1, 1'b1, 7'd0);
    add(3199, 0, 1'b0, 1'b0, 7'd0);
    add(3200, 0, 1'b1, 1'b0, 7'd0);
    add(55999, 0, 1'b1, 1'b0, 7'd0);
    add(56000, 0, 1'b1, 1'b1, 7'd0);
    add(63999, 0, 1'b1, 1'b1, 7'd0);
    add(64000, 0, 1'b1, 1'b1, 7'd1);
    add(64010, 0, 1'b1, 1'b1, 7'd1);
    add(64010, 1, 1'b1, 1'b1, 7'd1);
    add(64010, 2, 1'b1, 1'b1, 7'd43);
    n_first = vecs.size();
    // Timeline after the mid-frame reset is released
    add(0, 0, 1'b0, 1'b0, 7'd0);
    add(0, 1, 1'b0, 1'b0, 7'd0);
    add(0, 2, 1'b0, 1'b0, 7'd0);
    add(8, 2, 1'b1, 1'b0, 7'd0);
    add(16, 1, 1'b1, 1'b0, 7'd0);
    add(32, 1, 1'b1, 1'b1, 7'd0);
    add(140, 2, 1'b1, 1'b1, 7'd0);
    add(3199, 0, 1'b0, 1'b0, 7'd0);
    add(3200, 0, 1'b1, 1'b0, 7'd0);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_vecs(0, n_first);

    // Mid-DISP reset: outputs drop at once and stay down while held
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check("rst_async", d, 1'b0, 1'b0, 7'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("rst_held", d, 1'b0, 1'b0, 7'd0);
    reset = 1'b0;
    run_vecs(n_first, vecs.size());

    // Address range: d2 reaches row 95 but never 96
    @(negedge clk);
    n_checks++;
    if (max_ad[2] != 95) begin
      n_fail++;
      $display("FAIL addr_max dut2: got max addr=%0d, expected 95", max_ad[2]);
    end
    n_checks++;
    if (max_ad[1] != 1) begin
      n_fail++;
      $display("FAIL addr_max dut1: got max addr=%0d, expected 1", max_ad[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
